ub_row_streamer: RTL
====================

// Module: ub_row_streamer
// PURPOSE
//   Bulk-read master for the unified buffer row port: walks a programmed run of row addresses,
//   issues brden/brdaddr, captures the 1-cycle-latency brddata rows and presents them as a
//   valid/ready row stream toward the systolic-array feeder. Never drops or duplicates a row
//   under back-pressure. It is the reading end of the bulk interface the DMA writes through.
// PARAMETERS
//   SA_LENGTH   256  bytes per row (row = SA_LENGTH x 8-bit lanes)
//   ADDR_WIDTH  10   word-address bits per bank
//   NO_BANKS    8    bank count; RowAddrWidth = ADDR_WIDTH + $clog2(NO_BANKS) (localparam)
// PORTS
//   CLK        in   1              clock, all logic posedge
//   ASYNC_RST  in   1              asynchronous reset, active-high
//   SYNC_RST   in   1              synchronous clear, same effect as ASYNC_RST, one cycle
//   start      in   1              launch a run; sampled in IDLE only, ignored while busy
//   base_addr  in   RowAddrWidth   first row address (low bits = bank, high bits = word)
//   row_count  in   RowAddrWidth+1 rows to stream; 0 legal
//   busy       out  1              high from cycle after accepted start until done
//   done       out  1              one-cycle pulse when run complete
//   brden      out  1              bulk read enable to buffer
//   brdaddr    out  RowAddrWidth   bulk read row address
//   brddata    in   8 x [SA_LENGTH] row returned by buffer, valid 1 cycle after brden
//   out_valid  out  1              stream row valid
//   out_ready  in   1              stream consumer ready
//   out_data   out  8 x [SA_LENGTH] stream row
//   out_last   out  1              qualifies final row of run
// BEHAVIOUR
//   Reset: busy=0 done=0 brden=0 brdaddr=0 out_valid=0 out_last=0 out_data=0; FSM=IDLE; FIFO empty.
//   FSM IDLE->RUN on start&&row_count!=0 (latch base, count); start&&row_count==0 -> done pulse next cycle, stay IDLE.
//   RUN: brden=1 when issued<count && (fifo_occ + in_flight) < 2; brdaddr = base+issued, modulo 2^RowAddrWidth (wrap).
//   RUN->DRAIN when last read issued; DRAIN->IDLE when FIFO empty and nothing in flight; done=1 that cycle+1, busy=0.
//   Read return: in_flight set by brden, brddata pushed into 2-entry FIFO next cycle; push never finds FIFO full (credit rule).
//   Stream: out_valid=FIFO non-empty; pop on out_valid&&out_ready; out_data/out_last held stable while valid&&!ready.
//   out_last=1 only on row index count-1. Push and pop in same cycle allowed, occupancy unchanged.
//   Throughput: 1 row/cycle with out_ready held high; first out_valid 2 cycles after accepted start.
//   ASYNC_RST/SYNC_RST mid-run: abort immediately, FIFO flushed, no done pulse, in-flight return discarded.
//   Buffer EN is tied high at top level; this block does not drive it.
// CONFIGURATION
//   UB_STREAMER_STALL_CNT_EN defined: extra port stall_cycles out 32 = count of cycles with
//     out_valid&&!out_ready since last accepted start; saturates at 2^32-1; reset 0.
//   Undefined: port absent, no counter logic.
// STRUCTURE
//   ub_pkg: streamer_state_e {IDLE,RUN,DRAIN}; function row_addr_width(ADDR_WIDTH,NO_BANKS).
//   Sub-module ub_row_skid_fifo: 2-entry row FIFO (push/pop/occ, same-cycle push+pop).
// TESTING
//   Run base=5 count=4, out_ready=1 -> brdaddr 5,6,7,8 consecutive; 4 rows in order; out_last on 4th; done once.
//   count=0 start -> done pulse next cycle, brden never asserted, busy stays 0.
//   base=2^RowAddrWidth-2 count=4 -> addresses wrap: max-1, max, 0, 1.
//   count=6, out_ready low 10 cycles mid-run -> brden stops after 2 outstanding, no loss/dup, data held stable.
//   ASYNC_RST pulse after 2 rows -> outputs at reset values, no done; new start runs cleanly.
//   UB_STREAMER_STALL_CNT_EN, count=3, out_ready low 7 cycles -> stall_cycles=7, cleared on next start.

Source files
------------

// File: rtl/ub_pkg.sv
// Shared types and helpers for the unified-buffer row streamer.
package ub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} streamer_state_e;

    function automatic int row_addr_width(input int addr_width, input int no_banks);
        return addr_width + $clog2(no_banks);
    endfunction

endpackage

// File: rtl/ub_row_skid_fifo.sv
// Two-entry row FIFO between the buffer read return and the output stream.
// Push and pop may happen in the same cycle; the head entry is presented combinationally.
module ub_row_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   occ,
    output logic         empty
);

    logic [1:0][W-1:0] mem;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              pop_ok;

    assign empty     = (occ == 2'd0);
    assign pop_ok    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (clr) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) rd_ptr <= ~rd_ptr;
            case ({push, pop_ok})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/ub_row_streamer.sv
// Bulk-read master for the unified buffer row port: walks a run of row addresses and
// streams the returned rows as valid/ready. UB_STREAMER_STALL_CNT_EN adds a stall counter.
module ub_row_streamer
    import ub_pkg::*;
#(
    parameter int  SA_LENGTH    = 256,
    parameter int  ADDR_WIDTH   = 10,
    parameter int  NO_BANKS     = 8,
    localparam int RowAddrWidth = row_addr_width(ADDR_WIDTH, NO_BANKS)
) (
    input  logic                          CLK,
    input  logic                          ASYNC_RST,
    input  logic                          SYNC_RST,
    input  logic                          start,
    input  logic [RowAddrWidth-1:0]       base_addr,
    input  logic [RowAddrWidth:0]         row_count,
    output logic                          busy,
    output logic                          done,
    output logic                          brden,
    output logic [RowAddrWidth-1:0]       brdaddr,
    input  logic [SA_LENGTH-1:0][7:0]     brddata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SA_LENGTH-1:0][7:0]     out_data,
`ifdef UB_STREAMER_STALL_CNT_EN
    output logic [31:0]                   stall_cycles,
`endif
    output logic                          out_last
);

    localparam int                    RowBits = 8 * SA_LENGTH;
    localparam logic [RowAddrWidth:0] CntOne  = 1;

    streamer_state_e         state_q, state_d;
    logic [RowAddrWidth-1:0] base_q;
    logic [RowAddrWidth:0]   count_q, issued_q, pushed_q;
    logic                    in_flight_q, done_q;
    logic                    pop, fifo_empty;
    logic [1:0]              occ;
    logic [2:0]              credit_used;
    logic [RowBits:0]        push_data, head;

    assign pop       = out_valid && out_ready;
    assign out_valid = !fifo_empty;
    assign out_data  = head[RowBits-1:0];
    assign out_last  = out_valid && head[RowBits];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign brdaddr   = brden ? base_q + issued_q[RowAddrWidth-1:0] : '0;
    assign push_data = {(pushed_q == count_q - CntOne), brddata};

    // A row popped this cycle frees its slot before the new read can return,
    // which is what lets the stream sustain one row per cycle.
    assign credit_used = {1'b0, occ} + {2'b0, in_flight_q} - {2'b0, pop};

    always_comb begin
        state_d = state_q;
        brden   = 1'b0;
        case (state_q)
            IDLE:  if (start && row_count != '0) state_d = RUN;
            RUN: begin
                brden = (issued_q < count_q) && (credit_used < 3'd2);
                if (brden && (issued_q + CntOne == count_q)) state_d = DRAIN;
            end
            DRAIN: if (fifo_empty && !in_flight_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            state_q     <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            pushed_q    <= '0;
            in_flight_q <= 1'b0;
            done_q      <= 1'b0;
        end else if (SYNC_RST) begin
            state_q     <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            pushed_q    <= '0;
            in_flight_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= brden;
            done_q      <= (state_q == IDLE && start && row_count == '0) ||
                           (state_q == DRAIN && state_d == IDLE);
            if (state_q == IDLE && start) begin
                base_q   <= base_addr;
                count_q  <= row_count;
                issued_q <= '0;
                pushed_q <= '0;
            end else begin
                if (brden)       issued_q <= issued_q + CntOne;
                if (in_flight_q) pushed_q <= pushed_q + CntOne;
            end
        end
    end

    ub_row_skid_fifo #(.W(RowBits + 1)) u_fifo (
        .clk       (CLK),
        .rst       (ASYNC_RST),
        .clr       (SYNC_RST),
        .push      (in_flight_q),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head),
        .occ       (occ),
        .empty     (fifo_empty)
    );

`ifdef UB_STREAMER_STALL_CNT_EN
    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST)                        stall_cycles <= '0;
        else if (SYNC_RST)                    stall_cycles <= '0;
        else if (state_q == IDLE && start)    stall_cycles <= '0;
        else if (out_valid && !out_ready && stall_cycles != '1)
                                              stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule
